// File: rtl/shift_add_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_add_mul                                                              |
// | Sequential unsigned shift-and-add multiplier, 2N-bit product, valid/ready. |
// | Optional: SHIFT_ADD_MUL_EARLY_EXIT_EN stops once the multiplier is used up.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module shift_add_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplier;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_idle;
  logic           r_busy;
  logic           r_out_valid;

  logic [N-1:0]   w_mplier_next;
  logic           w_last;

  assign w_mplier_next = r_mplier >> 1;

`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
  // Finish as soon as no set multiplier bits remain after this step.
  assign w_last = (r_cnt == C_LAST) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == C_LAST);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_idle      <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{N{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
            r_idle   <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_idle      <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idle      <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst keeps in_ready low for the whole reset pulse.
  assign in_ready  = r_idle && rst;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign product   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_shift_add_mul                                                           |
// | Directed vectors with a scoreboard queue and an independent output monitor.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_shift_add_mul;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  shift_add_mul #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*N-1:0] prod;
    int             acc_cyc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   rise_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [N-1:0] mb);
    int h;
    h = 0;
`ifdef SHIFT_ADD_MUL_EARLY_EXIT_EN
    for (int i = 0; i < N; i++) if (mb[i]) h = i + 1;
    return (h == 0) ? 1 : h;
`else
    h = N;
    return h;
`endif
  endfunction

  // Monitor: every new presentation of out_valid consumes one expectation.
  logic prev_v = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_product: got %0d, expected no output", product);
      end else begin
        e = sb.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        rise_q.push_back(cyc);
      end
    end
    prev_v <= out_valid;
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [2*N-1:0] p);
    in_valid = 1'b1;
    a = ia;
    b = ib;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        sb.push_back('{p, cyc + 1, exp_lat(ib)});
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL accept_timeout: got in_ready 0, expected 1 for a=%0d b=%0d", ia, ib);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 200; k++) begin
      if (out_valid) return;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got out_valid 0 for 200 cycles, expected 1", name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrun;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_product", 32'(product), 0);
    rst = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // 13*11, then handoff one edge after out_valid rises
    issue(8'd13, 8'd11, 16'd143);
    in_valid = 1'b0;
    check("run_busy", 32'(busy), 1);
    check("run_in_ready", 32'(in_ready), 0);
    wait_valid("t1_valid");
    @(negedge clk);
    check("t1_in_ready_after", 32'(in_ready), 1);
    check("t1_valid_after", 32'(out_valid), 0);

    issue(8'd255, 8'd255, 16'd65025);
    in_valid = 1'b0;
    wait_valid("t2_valid");
    @(negedge clk);

    // Backpressure with a competing request held on the input
    out_ready = 1'b0;
    issue(8'd7, 8'd6, 16'd42);
    in_valid = 1'b0;
    wait_valid("bp_valid");
    in_valid = 1'b1;
    a = 8'd1;
    b = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_product", 32'(product), 42);
      check("bp_hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    issue(8'd1, 8'd1, 16'd1);
    in_valid = 1'b0;
    wait_valid("bp_next_valid");
    @(negedge clk);

    // Reset during RUN: nothing must be delivered
    in_valid = 1'b1;
    a = 8'd200;
    b = 8'd3;
    check("rs_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    nrun = (exp_lat(8'd3) > 3) ? 3 : exp_lat(8'd3) - 1;
    repeat (nrun) @(posedge clk);
    #1 check("rs_busy_before", 32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    check("rs_out_valid", 32'(out_valid), 0);
    check("rs_busy", 32'(busy), 0);
    check("rs_product", 32'(product), 0);
    check("rs_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rs_release_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    issue(8'd5, 8'd5, 16'd25);
    in_valid = 1'b0;
    wait_valid("rs_next_valid");
    @(negedge clk);

    // Back-to-back with in_valid held high
    rise_q.delete();
    issue(8'd2, 8'd3, 16'd6);
    issue(8'd4, 8'd5, 16'd20);
    issue(8'd0, 8'd9, 16'd0);
    in_valid = 1'b0;
    for (int k = 0; k < 200 && rise_q.size() < 3; k++) @(negedge clk);
    check("b2b_count", 32'(rise_q.size()), 3);
    if (rise_q.size() == 3) begin
      check("b2b_gap1", 32'(rise_q[1] - rise_q[0]), 32'(exp_lat(8'd5) + 2));
      check("b2b_gap2", 32'(rise_q[2] - rise_q[1]), 32'(exp_lat(8'd9) + 2));
    end
    @(negedge clk);

    // Latency corner cases (early-exit sensitive)
    issue(8'd5, 8'd0, 16'd0);
    in_valid = 1'b0;
    wait_valid("ee_b0");
    @(negedge clk);
    issue(8'd3, 8'h80, 16'd384);
    in_valid = 1'b0;
    wait_valid("ee_b80");
    @(negedge clk);
    issue(8'd9, 8'd3, 16'd27);
    in_valid = 1'b0;
    wait_valid("ee_b3");
    repeat (3) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
